led_bar_scheduler: RTL

- Sequences the 8-LED front-panel bar: picks which of four byte sources is shown, and when.
- Captures CPU bus bytes on strobes so short bus transfers stay visible.
- Three display modes: manual (switch-selected), auto-scan with a fixed dwell time per source, and freeze.
- Sits between the CPU/port datapath and the LED pins. Output is active-low because the LED commons are tied to +V.

---
 rtl/led_bar_scheduler.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/led_bar_scheduler.sv
// rtl/led_bar_scheduler.sv - front-panel LED bar source sequencer (optional lamp test: LEDBAR_LAMPTEST_EN)
module led_bar_scheduler #(
    parameter int DWELL_CYCLES    = 25000000,
    parameter int CNT_W           = 25,
    parameter int LAMPTEST_CYCLES = 50000000
) (
    input  logic       pll0_50MHz,
    input  logic       reset,
    input  logic [1:0] sw,
    input  logic       auto_en,
    input  logic       freeze,
    input  logic [7:0] cpuDO,
    input  logic [7:0] cpuDI,
    input  logic [7:0] portFFDO,
    input  logic [7:0] fbarSbcLeds,
    input  logic       wr_stb,
    input  logic       rd_stb,
    output logic [7:0] LEDoutData,
    output logic [1:0] sel_out,
    output logic       scan_active
);

    typedef enum logic [1:0] {ST_MANUAL, ST_SCAN, ST_FREEZE, ST_LAMPTEST} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

    if (DWELL_CYCLES < 2) begin : g_bad_dwell
        $error("DWELL_CYCLES must be at least 2");
    end
    if ((64'd1 << CNT_W) <= 64'(DWELL_CYCLES)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for DWELL_CYCLES");
    end
    if (LAMPTEST_CYCLES < 1) begin : g_bad_lamptest
        $error("LAMPTEST_CYCLES must be at least 1");
    end

`ifdef LEDBAR_LAMPTEST_EN
    localparam int               LT_W     = $clog2(LAMPTEST_CYCLES + 1);
    localparam logic [LT_W-1:0]  LT_LAST  = LT_W'(LAMPTEST_CYCLES - 1);
    localparam state_t           ST_RESET = ST_LAMPTEST;
    localparam logic [7:0]       LED_RST  = 8'h00;
    logic [LT_W-1:0] r_lt_cnt;
`else
    localparam state_t           ST_RESET = ST_MANUAL;
    localparam logic [7:0]       LED_RST  = 8'hFF;
`endif

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_sel;
    logic [1:0]       w_sel_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [7:0]       r_cap_do;
    logic [7:0]       r_cap_di;
    logic [7:0]       r_led;
    logic             r_scan_active;
    logic [7:0]       w_src;

    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_MANUAL: begin
                w_sel_next = sw;
                w_cnt_next = '0;
                if (freeze)
                    w_state_next = ST_FREEZE;
                else if (auto_en)
                    w_state_next = ST_SCAN;
            end
            ST_SCAN: begin
                // Counter keeps running on the exit cycle so a freeze resumes exactly where it left off
                if (r_cnt == CNT_LAST) begin
                    w_cnt_next = '0;
                    w_sel_next = r_sel + 2'd1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
                if (freeze)
                    w_state_next = ST_FREEZE;
                else if (!auto_en)
                    w_state_next = ST_MANUAL;
            end
            ST_FREEZE: begin
                if (!freeze)
                    w_state_next = auto_en ? ST_SCAN : ST_MANUAL;
            end
`ifdef LEDBAR_LAMPTEST_EN
            ST_LAMPTEST: begin
                if (r_lt_cnt == LT_LAST)
                    w_state_next = ST_MANUAL;
            end
`endif
            default: w_state_next = ST_MANUAL;
        endcase
    end

    always_comb begin
        w_src = r_cap_do;
        case (r_sel)
            2'b00:   w_src = r_cap_do;
            2'b01:   w_src = r_cap_di;
            2'b10:   w_src = portFFDO;
            default: w_src = fbarSbcLeds;
        endcase
    end

    always_ff @(posedge pll0_50MHz or posedge reset) begin
        if (reset) begin
            r_state       <= ST_RESET;
            r_sel         <= 2'b00;
            r_cnt         <= '0;
            r_cap_do      <= 8'h00;
            r_cap_di      <= 8'h00;
            r_led         <= LED_RST;
            r_scan_active <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_sel         <= w_sel_next;
            r_cnt         <= w_cnt_next;
            r_scan_active <= (w_state_next == ST_SCAN);
            if (wr_stb)
                r_cap_do <= cpuDO;
            if (rd_stb)
                r_cap_di <= cpuDI;
`ifdef LEDBAR_LAMPTEST_EN
            if (r_state == ST_LAMPTEST)
                r_led <= 8'h00;
            else if (r_state != ST_FREEZE)
                r_led <= ~w_src;
`else
            if (r_state != ST_FREEZE)
                r_led <= ~w_src;
`endif
        end
    end

`ifdef LEDBAR_LAMPTEST_EN
    always_ff @(posedge pll0_50MHz or posedge reset) begin
        if (reset)
            r_lt_cnt <= '0;
        else if (r_state == ST_LAMPTEST)
            r_lt_cnt <= r_lt_cnt + 1'b1;
    end
`endif

    assign LEDoutData  = r_led;
    assign sel_out     = r_sel;
    assign scan_active = r_scan_active;

endmodule
